// File: rtl/sys1_hiscore_xfer_if.sv
// Target-side bus of the high-score transfer engine: address, read/write data,
// write strobe and the game pause request.
interface sys1_hiscore_xfer_if;
    logic [15:0] HSAD;
    logic [7:0]  HSDO;
    logic [7:0]  HSDI;
    logic        HSWE;
    logic        PAUSE_N;

    modport master (output HSAD, output HSDI, output HSWE, output PAUSE_N, input HSDO);
    modport slave  (input HSAD, input HSDI, input HSWE, input PAUSE_N, output HSDO);
endinterface

// File: rtl/sys1_hiscore_xfer.sv
// High-score transfer engine: pauses the game, then copies up to four table
// described regions of target memory into a 1024x8 buffer (save) or back (load).
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for save_req / load_req, host owns the buffer
// PWAIT | PAUSE_N low, letting the game settle before touching it
// SETUP | pick the next non-empty table entry, or finish
// ADDR  | drive HSAD = start + byte
// RWAIT | read latency; at its end sample HSDO (save) or present HSDI (load)
// XFER  | write buffer (save) or raise HSWE (load)
// NEXT  | advance byte/bufptr, HSWE high for this one cycle on load
// FIN   | done pulse, release pause and busy
module sys1_hiscore_xfer #(
    parameter int PAUSE_CYC = 16,
    parameter int RD_LAT    = 2
) (
    input  logic        clk40M,
    input  logic        reset,
    input  logic        tbl_we,
    input  logic [1:0]  tbl_idx,
    input  logic [15:0] tbl_start,
    input  logic [7:0]  tbl_len,
    input  logic        save_req,
    input  logic        load_req,
    output logic        busy,
    output logic        done,
    input  logic [9:0]  buf_addr,
    input  logic [7:0]  buf_din,
    input  logic        buf_we,
    output logic [7:0]  buf_dout,
    sys1_hiscore_xfer_if.master tgt
);

    typedef enum logic [2:0] {
        S_IDLE, S_PWAIT, S_SETUP, S_ADDR, S_RWAIT, S_XFER, S_NEXT, S_FIN
    } state_t;

    // HSAD is registered on leaving ADDR, and SETUP costs one cycle, so PWAIT
    // is shortened to land the first access PAUSE_CYC cycles after PAUSE_N falls.
    localparam logic [7:0] PWAIT_LOAD = 8'(PAUSE_CYC - 3);
    localparam logic [7:0] RWAIT_LOAD = 8'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [2:0]  entry_q, entry_d;
    logic [7:0]  byte_q, byte_d;
    logic [9:0]  bufptr_q, bufptr_d;
    logic        is_save_q, is_save_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pause_n_q, pause_n_d;
    logic [15:0] hsad_q, hsad_d;
    logic [7:0]  hsdi_q, hsdi_d;
    logic        hswe_q, hswe_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic [7:0]  rd_q;

    logic [15:0] tbl_start_q [4];
    logic [7:0]  tbl_len_q [4];
    logic        all_zero;

    logic [7:0]  mem [1024];
    logic        mem_we;
    logic [9:0]  mem_waddr;
    logic [7:0]  mem_wdata;

    // Emptiness check sees a table write landing in the same cycle as the request.
    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (tbl_we && (tbl_idx == 2'(i))) begin
                if (tbl_len != 8'd0) all_zero = 1'b0;
            end else if (tbl_len_q[i] != 8'd0) begin
                all_zero = 1'b0;
            end
        end
    end

    // Transfer table, writable only while idle.
    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                tbl_start_q[i] <= 16'h0000;
                tbl_len_q[i]   <= 8'd0;
            end
        end else if (tbl_we && !busy_q) begin
            tbl_start_q[tbl_idx] <= tbl_start;
            tbl_len_q[tbl_idx]   <= tbl_len;
        end
    end

    // Next-state and datapath update for the transfer sequencer.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        entry_d   = entry_q;
        byte_d    = byte_q;
        bufptr_d  = bufptr_q;
        is_save_d = is_save_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        pause_n_d = pause_n_q;
        hsad_d    = hsad_q;
        hsdi_d    = hsdi_q;
        hswe_d    = 1'b0;
        rd_data_d = rd_data_q;
        mem_we    = buf_we && !busy_q;
        mem_waddr = buf_addr;
        mem_wdata = buf_din;

        case (state_q)
            S_IDLE: begin
                if (save_req || load_req) begin
                    is_save_d = save_req;
                    busy_d    = 1'b1;
                    entry_d   = 3'd0;
                    byte_d    = 8'd0;
                    bufptr_d  = 10'd0;
                    if (all_zero) begin
                        state_d = S_FIN;
                    end else begin
                        pause_n_d = 1'b0;
                        cnt_d     = PWAIT_LOAD;
                        state_d   = S_PWAIT;
                    end
                end
            end
            S_PWAIT: begin
                if (cnt_q == 8'd0) begin
                    entry_d  = 3'd0;
                    byte_d   = 8'd0;
                    bufptr_d = 10'd0;
                    state_d  = S_SETUP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_SETUP: begin
                if (entry_q[2]) begin
                    state_d = S_FIN;
                end else if (tbl_len_q[entry_q[1:0]] == 8'd0) begin
                    entry_d = entry_q + 3'd1;
                end else begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                hsad_d  = tbl_start_q[entry_q[1:0]] + {8'h00, byte_q};
                cnt_d   = RWAIT_LOAD;
                state_d = S_RWAIT;
            end
            S_RWAIT: begin
                if (cnt_q == 8'd0) begin
                    if (is_save_q) rd_data_d = tgt.HSDO;
                    else           hsdi_d    = rd_q;
                    state_d = S_XFER;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_XFER: begin
                if (is_save_q) begin
                    mem_we    = 1'b1;
                    mem_waddr = bufptr_q;
                    mem_wdata = rd_data_q;
                end else begin
                    hswe_d = 1'b1;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                // Leaving NEXT drops HSWE; ADDR then holds HSAD/HSDI one more cycle.
                bufptr_d = bufptr_q + 10'd1;
                if ((byte_q + 8'd1) == tbl_len_q[entry_q[1:0]]) begin
                    entry_d = entry_q + 3'd1;
                    byte_d  = 8'd0;
                    state_d = S_SETUP;
                end else begin
                    byte_d  = byte_q + 8'd1;
                    state_d = S_ADDR;
                end
            end
            S_FIN: begin
                done_d    = 1'b1;
                busy_d    = 1'b0;
                pause_n_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer and output registers.
    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            entry_q   <= 3'd0;
            byte_q    <= 8'd0;
            bufptr_q  <= 10'd0;
            is_save_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pause_n_q <= 1'b1;
            hsad_q    <= 16'h0000;
            hsdi_q    <= 8'h00;
            hswe_q    <= 1'b0;
            rd_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            entry_q   <= entry_d;
            byte_q    <= byte_d;
            bufptr_q  <= bufptr_d;
            is_save_q <= is_save_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pause_n_q <= pause_n_d;
            hsad_q    <= hsad_d;
            hsdi_q    <= hsdi_d;
            hswe_q    <= hswe_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Buffer write port, shared by the host (idle) and the save path (busy).
    always_ff @(posedge clk40M) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Single registered read port: host address when idle, bufptr while busy.
    always_ff @(posedge clk40M or posedge reset) begin
        if (reset) rd_q <= 8'h00;
        else       rd_q <= mem[busy_q ? bufptr_q : buf_addr];
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign buf_dout    = rd_q;
    assign tgt.HSAD    = hsad_q;
    assign tgt.HSDI    = hsdi_q;
    assign tgt.HSWE    = hswe_q;
    assign tgt.PAUSE_N = pause_n_q;

endmodule

// File: tb/tb_sys1_hiscore_xfer.sv
// Bench for the high-score transfer engine: target memory model, directed
// corner sequences, a table of transfer cases and randomized transfers.
module tb_sys1_hiscore_xfer;
    localparam int PAUSE_CYC = 16;

    logic        clk40M = 1'b0;
    logic        reset = 1'b0;
    logic        tbl_we = 1'b0;
    logic [1:0]  tbl_idx = '0;
    logic [15:0] tbl_start = '0;
    logic [7:0]  tbl_len = '0;
    logic        save_req = 1'b0;
    logic        load_req = 1'b0;
    logic        busy, done;
    logic [9:0]  buf_addr = '0;
    logic [7:0]  buf_din = '0;
    logic        buf_we = 1'b0;
    logic [7:0]  buf_dout;

    sys1_hiscore_xfer_if bus();

    sys1_hiscore_xfer #(.PAUSE_CYC(PAUSE_CYC), .RD_LAT(2)) dut (
        .clk40M(clk40M), .reset(reset),
        .tbl_we(tbl_we), .tbl_idx(tbl_idx), .tbl_start(tbl_start), .tbl_len(tbl_len),
        .save_req(save_req), .load_req(load_req), .busy(busy), .done(done),
        .buf_addr(buf_addr), .buf_din(buf_din), .buf_we(buf_we), .buf_dout(buf_dout),
        .tgt(bus)
    );

    always #5 clk40M = ~clk40M;

    typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
    typedef struct packed {
        logic             is_save;
        logic [3:0][15:0] st;
        logic [3:0][7:0]  ln;
        logic [11:0]      exp_total;
        logic             exp_pause;
    } case_t;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  tmem [65536];
    logic [7:0]  hsdo_pipe = 8'h00;
    wr_t         wq [$];
    wr_t         mon_w;
    int          done_cnt = 0;
    int          viol = 0;
    bit          pause_seen = 0;
    bit          cur_is_save = 0;
    logic        prev_hswe = 1'b0;
    logic [15:0] prev_hsad = '0;
    logic [7:0]  prev_hsdi = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Target memory: read data appears one cycle after HSAD changes, writes land on HSWE.
    always @(negedge clk40M) begin
        bus.HSDO  = hsdo_pipe;
        hsdo_pipe = tmem[bus.HSAD];
        if (done === 1'b1) done_cnt++;
        if (bus.PAUSE_N === 1'b0) pause_seen = 1;
        if (bus.HSWE === 1'b1) begin
            if (cur_is_save || bus.PAUSE_N !== 1'b0 || prev_hswe) viol++;
            chk("hswe_setup", {bus.HSAD, bus.HSDI}, {prev_hsad, prev_hsdi});
            mon_w.a = bus.HSAD;
            mon_w.d = bus.HSDI;
            wq.push_back(mon_w);
            tmem[bus.HSAD] = bus.HSDI;
        end else if (prev_hswe && !reset) begin
            chk("hswe_hold", {bus.HSAD, bus.HSDI}, {prev_hsad, prev_hsdi});
        end
        prev_hswe = bus.HSWE;
        prev_hsad = bus.HSAD;
        prev_hsdi = bus.HSDI;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk40M);
    endtask

    task automatic tbl_wr(input logic [1:0] i, input logic [15:0] s, input logic [7:0] l);
        tbl_we = 1'b1; tbl_idx = i; tbl_start = s; tbl_len = l;
        tick();
        tbl_we = 1'b0;
    endtask

    task automatic buf_wr(input logic [9:0] a, input logic [7:0] d);
        buf_we = 1'b1; buf_addr = a; buf_din = d;
        tick();
        buf_we = 1'b0;
    endtask

    task automatic buf_rd(input logic [9:0] a, output logic [7:0] d);
        buf_addr = a;
        tick();
        d = buf_dout;
    endtask

    task automatic start_req(input logic s, input logic l);
        save_req = s; load_req = l;
        tick();
        save_req = 1'b0; load_req = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int k = 0;
        while (done !== 1'b1 && k < 4000) begin
            tick();
            k++;
        end
        chk(nm, done, 1'b1);
    endtask

    task automatic clear_mon(input bit is_save);
        wq.delete();
        done_cnt = 0; viol = 0; pause_seen = 0;
        cur_is_save = is_save;
    endtask

    // Program the table, build the expected result from the region list, run, compare.
    task automatic run_case(input logic is_save, input logic [3:0][15:0] st,
                            input logic [3:0][7:0] ln, input int exp_total, input int exp_pause);
        logic [7:0]  eb [$];
        wr_t         ew [$];
        wr_t         w;
        logic [7:0]  d;
        int          tot = 0;
        for (int i = 0; i < 4; i++) tbl_wr(2'(i), st[i], ln[i]);
        for (int e = 0; e < 4; e++) begin
            for (int k = 0; k < int'(ln[e]); k++) begin
                w.a = st[e] + 16'(k);
                w.d = 8'($urandom);
                if (is_save) eb.push_back(tmem[w.a]);
                else         ew.push_back(w);
                tot++;
            end
        end
        if (!is_save) for (int j = 0; j < tot; j++) buf_wr(10'(j), ew[j].d);
        clear_mon(is_save);
        start_req(is_save, !is_save);
        wait_done("case_done_timeout");
        tick(3);
        chk("case_done_count", done_cnt, 1);
        chk("case_busy_after", busy, 1'b0);
        chk("case_pause_n_after", bus.PAUSE_N, 1'b1);
        chk("case_pause_seen", pause_seen, (exp_pause >= 0) ? exp_pause : int'(tot != 0));
        chk("case_hswe_rules", viol, 0);
        if (is_save) begin
            chk("save_no_writes", wq.size(), 0);
            for (int j = 0; j < tot; j++) begin
                buf_rd(10'(j), d);
                chk("save_buf", d, eb[j]);
            end
        end else begin
            chk("load_write_count", wq.size(), (exp_total >= 0) ? exp_total : tot);
            for (int j = 0; j < tot && j < wq.size(); j++) chk("load_write", wq[j], ew[j]);
        end
    endtask

    initial begin
        case_t       vec [6];
        logic [7:0]  d, keep;
        logic [3:0][15:0] st;
        logic [3:0][7:0]  ln;
        wr_t         exp_w [4];
        int          k;

        vec[0] = {1'b1, {16'h1300, 16'h1200, 16'h1100, 16'h1000}, {8'd0, 8'd3, 8'd0, 8'd2}, 12'd5, 1'b1};
        vec[1] = {1'b0, {16'h4000, 16'h8000, 16'h0000, 16'hFFFF}, {8'd0, 8'd1, 8'd0, 8'd2}, 12'd3, 1'b1};
        vec[2] = {1'b1, {16'h0040, 16'h0030, 16'h0020, 16'h0010}, {8'd0, 8'd0, 8'd0, 8'd0}, 12'd0, 1'b0};
        vec[3] = {1'b0, {16'h2222, 16'h0000, 16'h0000, 16'h0000}, {8'd4, 8'd0, 8'd0, 8'd0}, 12'd4, 1'b1};
        vec[4] = {1'b1, {16'h0000, 16'h0000, 16'h0000, 16'h0100}, {8'd0, 8'd0, 8'd0, 8'd255}, 12'd255, 1'b1};
        vec[5] = {1'b0, {16'h0040, 16'h0030, 16'h0020, 16'h0010}, {8'd1, 8'd1, 8'd1, 8'd1}, 12'd4, 1'b1};

        for (int i = 0; i < 65536; i++) tmem[i] = 8'($urandom);

        // Reset values
        #1 reset = 1'b1;
        tick(2);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_hswe", bus.HSWE, 1'b0);
        chk("rst_pause_n", bus.PAUSE_N, 1'b1);
        chk("rst_hsad", bus.HSAD, 16'h0000);
        chk("rst_hsdi", bus.HSDI, 8'h00);
        chk("rst_buf_dout", buf_dout, 8'h00);
        reset = 1'b0;
        tick(2);

        // Host buffer port
        buf_wr(10'h000, 8'h5A);
        buf_wr(10'h3FF, 8'hC3);
        buf_rd(10'h000, d); chk("host_rd_0", d, 8'h5A);
        buf_rd(10'h3FF, d); chk("host_rd_3ff", d, 8'hC3);

        // Save of three bytes at C000h, with pause-to-access timing
        tmem[16'hC000] = 8'h11; tmem[16'hC001] = 8'h22; tmem[16'hC002] = 8'h33;
        tbl_wr(2'd0, 16'hC000, 8'd3);
        clear_mon(1);
        start_req(1'b1, 1'b0);
        chk("save_pause_low", bus.PAUSE_N, 1'b0);
        chk("save_busy", busy, 1'b1);
        k = 0;
        while (bus.HSAD !== 16'hC000 && k < 100) begin tick(); k++; end
        chk("pause_to_first_addr", k, PAUSE_CYC);
        wait_done("save_done_timeout");
        tick(3);
        chk("save_done_count", done_cnt, 1);
        chk("save_pause_n_after", bus.PAUSE_N, 1'b1);
        buf_rd(10'd0, d); chk("save_buf0", d, 8'h11);
        buf_rd(10'd1, d); chk("save_buf1", d, 8'h22);
        buf_rd(10'd2, d); chk("save_buf2", d, 8'h33);

        // Load across the 16-bit address wrap plus a second entry
        buf_wr(10'd0, 8'hA1); buf_wr(10'd1, 8'hA2); buf_wr(10'd2, 8'hA3); buf_wr(10'd3, 8'hA4);
        tbl_wr(2'd0, 16'hFFFE, 8'd3);
        tbl_wr(2'd1, 16'hD800, 8'd1);
        exp_w[0] = {16'hFFFE, 8'hA1}; exp_w[1] = {16'hFFFF, 8'hA2};
        exp_w[2] = {16'h0000, 8'hA3}; exp_w[3] = {16'hD800, 8'hA4};
        clear_mon(0);
        start_req(1'b0, 1'b1);
        wait_done("load_done_timeout");
        tick(3);
        chk("load_count", wq.size(), 4);
        for (int j = 0; j < 4 && j < wq.size(); j++) chk("load_order", wq[j], exp_w[j]);
        chk("load_hswe_rules", viol, 0);
        chk("load_done_count", done_cnt, 1);

        // Simultaneous requests: save wins; a repeat save_req while busy is ignored
        tbl_wr(2'd0, 16'h3000, 8'd4);
        tbl_wr(2'd1, 16'h0000, 8'd0);
        keep = tmem[16'h3002];
        clear_mon(1);
        start_req(1'b1, 1'b1);
        tick(3);
        start_req(1'b1, 1'b0);
        wait_done("prio_done_timeout");
        tick(60);
        chk("prio_done_count", done_cnt, 1);
        chk("prio_no_writes", wq.size(), 0);
        for (int j = 0; j < 4; j++) begin
            buf_rd(10'(j), d);
            chk("prio_save_buf", d, tmem[16'h3000 + 16'(j)]);
        end

        // Table write on the acceptance cycle counts; writes while busy do not
        for (int i = 0; i < 4; i++) tbl_wr(2'(i), 16'h0000, 8'd0);
        tmem[16'h6000] = ~keep;
        clear_mon(1);
        tbl_we = 1'b1; tbl_idx = 2'd2; tbl_start = 16'h5000; tbl_len = 8'd2;
        save_req = 1'b1;
        tick();
        tbl_we = 1'b0; save_req = 1'b0;
        tbl_wr(2'd3, 16'h6000, 8'd7);
        wait_done("same_cycle_done_timeout");
        tick(2);
        chk("same_cycle_pause", pause_seen, 1);
        buf_rd(10'd0, d); chk("same_cycle_buf0", d, tmem[16'h5000]);
        buf_rd(10'd1, d); chk("same_cycle_buf1", d, tmem[16'h5001]);
        start_req(1'b1, 1'b0);
        wait_done("frozen_done_timeout");
        tick(2);
        buf_rd(10'd2, d); chk("frozen_table_buf2", d, keep);

        // Empty table: done two cycles after the request, no pause, no writes
        for (int i = 0; i < 4; i++) tbl_wr(2'(i), 16'h0000, 8'd0);
        clear_mon(0);
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        chk("empty_busy", busy, 1'b1);
        chk("empty_done_early", done, 1'b0);
        tick();
        chk("empty_done", done, 1'b1);
        chk("empty_busy_clear", busy, 1'b0);
        tick();
        chk("empty_done_once", done, 1'b0);
        tick(3);
        chk("empty_no_pause", pause_seen, 0);
        chk("empty_no_writes", wq.size(), 0);

        // Reset in the middle of a load, then an empty-table save
        tbl_wr(2'd0, 16'h7000, 8'd2);
        clear_mon(0);
        start_req(1'b0, 1'b1);
        k = 0;
        while (bus.HSAD !== 16'h7000 && k < 100) begin tick(); k++; end
        chk("midrst_reach_addr", bus.HSAD, 16'h7000);
        reset = 1'b1;
        #1;
        chk("midrst_pause_n", bus.PAUSE_N, 1'b1);
        chk("midrst_hswe", bus.HSWE, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_hsad", bus.HSAD, 16'h0000);
        tick();
        reset = 1'b0;
        tick(2);
        clear_mon(1);
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        chk("postrst_busy", busy, 1'b1);
        tick();
        chk("postrst_done", done, 1'b1);
        tick();
        chk("postrst_pause", pause_seen, 0);
        chk("postrst_no_writes", wq.size(), 0);

        // Table of transfer cases
        for (int i = 0; i < 6; i++)
            run_case(vec[i].is_save, vec[i].st, vec[i].ln, int'(vec[i].exp_total), int'(vec[i].exp_pause));

        // Randomized transfers
        for (int r = 0; r < 20; r++) begin
            for (int e = 0; e < 4; e++) begin
                st[e] = ($urandom_range(0, 3) == 0) ? (16'hFFF0 + 16'($urandom_range(0, 15)))
                                                    : 16'($urandom);
                ln[e] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
            end
            run_case(1'($urandom_range(0, 1)), st, ln, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sys1_hiscore_xfer.md
SYS1_HISCORE_XFER -- requirements
Module: sys1_hiscore_xfer

Interface
REQ-001 PAUSE_CYC, default 16: clock cycles from PAUSE_N falling to the first target access.
REQ-002 RD_LAT, default 2: clock cycles from HSAD change to HSDO sampling.
REQ-003 clk40M  in  1  sole clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 tbl_we  in  1  table write strobe; ignored while busy.
REQ-006 tbl_idx  in  2  table entry index, 0..3.
REQ-007 tbl_start  in  16  entry start address in target space.
REQ-008 tbl_len  in  8  entry length in bytes; 0 disables the entry.
REQ-009 save_req  in  1  start a save (target -> buffer); sampled in IDLE only.
REQ-010 load_req  in  1  start a load (buffer -> target); sampled in IDLE only.
REQ-011 busy  out  1  high from request acceptance until done.
REQ-012 done  out  1  one-cycle completion pulse.
REQ-013 buf_addr  in  10  host port address into the 1024x8 buffer.
REQ-014 buf_din  in  8  host write data.
REQ-015 buf_we  in  1  host write strobe; ignored while busy.
REQ-016 buf_dout  out  8  host read data, registered, 1-cycle latency; undefined while busy.
REQ-017 HSAD  out  16  target address.
REQ-018 HSDO  in  8  target read data.
REQ-019 HSDI  out  8  target write data.
REQ-020 HSWE  out  1  target write strobe.
REQ-021 PAUSE_N  out  1  active-low game pause; low for the whole transfer.

Function
REQ-022 States: IDLE, PWAIT, SETUP, ADDR, RWAIT, XFER, NEXT, FIN.
REQ-023 IDLE: save_req has priority when both requests are high (load dropped); accepting either sets busy, drives PAUSE_N low and enters PWAIT.
REQ-024 If all four tbl_len are 0: skip PWAIT, go to FIN next cycle; PAUSE_N stays high.
REQ-025 PWAIT: count PAUSE_CYC cycles, then enter SETUP with entry=0, byte=0, bufptr=0.
REQ-026 SETUP: skip entries with len 0; when entry>3, enter FIN.
REQ-027 ADDR: HSAD = (tbl_start[entry] + byte) mod 2^16.
  - Save: enter RWAIT for RD_LAT cycles; XFER then writes HSDO into buffer[bufptr].
  - Load: HSDI = buffer[bufptr] is valid one cycle before HSWE; HSWE is high for exactly one cycle.
  - HSAD and HSDI are held one cycle after HSWE falls.
REQ-028 NEXT: bufptr++, byte++; when byte==len, set entry++, byte=0 and return to SETUP; otherwise go to ADDR.
REQ-029 bufptr is 10 bits and never wraps (max total 4x255=1020).
REQ-030 FIN: done=1 for one cycle; PAUSE_N=1, busy=0 and return to IDLE in the same cycle.
REQ-031 HSWE is never high during a save, in IDLE, or while PAUSE_N=1.
REQ-032 Table writes landing on the same cycle a request is accepted take effect; the table is frozen while busy.

Reset
REQ-033 Asserting reset, including mid-transfer, forces: state IDLE; busy=0, done=0, HSWE=0, PAUSE_N=1, HSAD=0, HSDI=0, buf_dout=0; all tbl_len=0, all tbl_start=0.
REQ-034 Buffer contents are not cleared by reset.

Verification
REQ-035 Save: entry0 = (C000h, 3), target holds 11,22,33, save_req -> PAUSE_N low 16 cycles before the first HSAD=C000h; buffer[0..2]=11,22,33; one done pulse; PAUSE_N high.
REQ-036 Load: entries (FFFEh, 3) and (D800h, 1), buffer = A1,A2,A3,A4, load_req -> four one-cycle HSWE writes in order FFFEh=A1, FFFFh=A2, 0000h=A3, D800h=A4.
REQ-037 save_req and load_req on the same cycle -> save only; a second save_req while busy -> ignored, exactly one done.
REQ-038 All tbl_len=0, load_req -> done 2 cycles later; PAUSE_N never low; HSWE never high.
REQ-039 Reset asserted during load RWAIT/XFER -> same cycle PAUSE_N=1, HSWE=0, busy=0; a later save_req with an empty table completes per REQ-024.
